card_grid_draw: RTL and testbench
=================================

// Module: card_grid_draw
// PURPOSE
// Parametrised, pipelined pixel renderer for the memory-card game grid; successor to the combinational card drawer.
// Maps VGA pixel counters to a ROWS x COLS card grid and produces the 3-bit RGB for the current pixel.
// Holds a per-card symbol table and per-card face state, with a frame-timed flip animation.
// Sits between the VGA sync counters and the RGB output pins; the game FSM drives reveal/matched/cursor.
// PARAMETERS
// COLS 4 - grid columns;  ROWS 4 - grid rows;  N = COLS*ROWS cards, IW = $clog2(N)
// CARD_W 80 / CARD_H 90 - card size in pixels;  GAP 20 - spacing between cards, both axes
// X0 40 / Y0 30 - top-left pixel of card 0;  HW 10 - pixel counter width
// SYM_W 4 - symbol index width;  FLIP_FRAMES 8 - flip duration in frames (power of 2, >=2)
// PORTS
// clk         in   1       pixel clock
// reset_n     in   1       asynchronous reset, active-low
// HCount      in   HW      horizontal pixel counter
// VCount      in   HW      vertical pixel counter
// video_on    in   1       visible-area qualifier
// frame_tick  in   1       one-cycle pulse per frame
// sym_we      in   1       symbol table write strobe
// sym_addr    in   IW      card index to write
// sym_data    in   SYM_W   symbol value
// reveal      in   N       level per card: 1 = face up requested
// matched     in   N       level per card: card already paired
// cursor_en   in   1       draw cursor
// cursor      in   IW      cursor card index
// rgb         out  3       pixel colour, registered
// card_hit    out  1       pixel lies on a card
// card_idx    out  IW      card under pixel (0 when card_hit=0)
// busy        out  1       any card flip in progress
// BEHAVIOUR
// - One clock; reset is asynchronous and active-low: reset_n low clears rgb, card_hit, card_idx, busy, all symbols,
//   face[] and flip counters to 0 immediately, including mid-flip; first valid pixel 2 cycles after release.
// - Pipeline latency is exactly 2 clocks from HCount/VCount/video_on to rgb/card_hit/card_idx.
// - Stage 1: per-column/row range compare (no dividers) gives col, row, lx = HCount-colX, ly = VCount-rowY.
//   Pixels in gaps or outside the grid give card_hit=0 and rgb=000.
// - Stage 2: symbol lookup and colour priority, highest first:
//   video_on=0 -> 000; off-card -> 000; cursor_en and idx==cursor and lx<2|lx>=CARD_W-2|ly<2|ly>=CARD_H-2 -> 100;
//   flip active -> 110; face=0 -> 001; matched -> 010;
//   face=1 inner box (lx in [CARD_W/4, 3*CARD_W/4), ly in [CARD_H/4, 3*CARD_H/4)) -> sym[2:0]; face=1 else -> 111.
// - Symbol write on the clk edge with sym_we=1; it is visible to any stage-2 lookup in the following cycles.
// - Flip FSM per card: IDLE -> FLIP when frame_tick, cnt==0 and reveal[i]!=face[i]: cnt<=FLIP_FRAMES, tgt<=reveal[i].
//   In FLIP each frame_tick decrements cnt; on reaching 0 face<=tgt, back to IDLE.
//   A reveal change mid-flip is ignored until the flip ends; the next frame_tick starts a new flip.
// - busy = OR of (cnt!=0), registered.
// - sym_we, frame_tick and pixel traffic may coincide; all are independent.
// STRUCTURE
// - Package card_grid_pkg: colour constants (BG, BACK, MATCH, FACE, FLIP, CURSOR) and typedef card_state_t {IDLE, FLIP}.
// - Sub-module card_flip_ctrl: one card's cnt/tgt/face FSM, instantiated N times via generate.
// TESTING (default parameters)
// - Reset, reveal=0, cursor_en=0, HCount=140, VCount=75, video_on=1 -> after 2 clk: rgb=001, card_hit=1, card_idx=1.
// - HCount=125, VCount=75 (gap) -> rgb=000, card_hit=0; HCount=140, video_on=0 -> rgb=000.
// - Write sym[1]=5, set reveal[1]=1, 8 frame_ticks -> busy=1 and rgb=110 at (140,75) for 8 ticks;
//   then (180,75) rgb=101 and (145,35) rgb=111.
// - cursor_en=1, cursor=1, pixel (140,75) -> rgb=100; pixel (145,35) with matched[1]=1 -> rgb=010.
// - reveal[1] toggled 1->0 at tick 3 of a flip -> flip ends face=1 at tick 8, second flip ends face=0 at tick 17.
// - reset_n low at tick 4 of a flip -> rgb=000, busy=0 at once; after release, card 1 draws 001.

Source files
------------

// File: rtl/card_grid_pkg.sv
// Shared colour codes and flip-state encoding for the memory-card grid renderer.
package card_grid_pkg;

    localparam logic [2:0] CLR_BG     = 3'b000;
    localparam logic [2:0] CLR_BACK   = 3'b001;
    localparam logic [2:0] CLR_MATCH  = 3'b010;
    localparam logic [2:0] CLR_FACE   = 3'b111;
    localparam logic [2:0] CLR_FLIP   = 3'b110;
    localparam logic [2:0] CLR_CURSOR = 3'b100;

    typedef enum logic {IDLE, FLIP} card_state_t;

endpackage

// File: rtl/card_flip_ctrl.sv
// One card's flip animation: counts FLIP_FRAMES frame ticks, then commits the latched target face.
module card_flip_ctrl
    import card_grid_pkg::*;
#(
    parameter int FLIP_FRAMES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic frameTick,
    input  logic reveal,
    output logic face,
    output logic flipping
);
    localparam int CNTW = $clog2(FLIP_FRAMES) + 1;

    card_state_t     state;
    logic [CNTW-1:0] cnt;
    logic            tgt;

    // reveal is sampled only when a flip starts; changes during a flip wait for the next tick after it ends
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            tgt   <= 1'b0;
            face  <= 1'b0;
        end else if (frameTick) begin
            case (state)
                IDLE: if (cnt == '0 && reveal != face) begin
                    cnt   <= CNTW'(FLIP_FRAMES);
                    tgt   <= reveal;
                    state <= FLIP;
                end
                FLIP: if (cnt == CNTW'(1)) begin
                    cnt   <= '0;
                    face  <= tgt;
                    state <= IDLE;
                end else begin
                    cnt <= cnt - CNTW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign flipping = (cnt != '0);

endmodule

// File: rtl/card_grid_draw.sv
// Two-stage pixel renderer: stage 1 locates the card under the pixel, stage 2 picks its colour.
module card_grid_draw
    import card_grid_pkg::*;
#(
    parameter int COLS        = 4,
    parameter int ROWS        = 4,
    parameter int CARD_W      = 80,
    parameter int CARD_H      = 90,
    parameter int GAP         = 20,
    parameter int X0          = 40,
    parameter int Y0          = 30,
    parameter int HW          = 10,
    parameter int SYM_W       = 4,
    parameter int FLIP_FRAMES = 8,
    localparam int N          = COLS * ROWS,
    localparam int IW         = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [HW-1:0]    HCount,
    input  logic [HW-1:0]    VCount,
    input  logic             video_on,
    input  logic             frame_tick,
    input  logic             sym_we,
    input  logic [IW-1:0]    sym_addr,
    input  logic [SYM_W-1:0] sym_data,
    input  logic [N-1:0]     reveal,
    input  logic [N-1:0]     matched,
    input  logic             cursor_en,
    input  logic [IW-1:0]    cursor,
    output logic [2:0]       rgb,
    output logic             card_hit,
    output logic [IW-1:0]    card_idx,
    output logic             busy
);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [N-1:0][SYM_W-1:0] symTab;
    logic [N-1:0]            face;
    logic [N-1:0]            flipping;

    for (genvar i = 0; i < N; i++) begin : g_card
        card_flip_ctrl #(.FLIP_FRAMES(FLIP_FRAMES)) u_flip (
            .clk      (clk),
            .rst_n    (reset_n),
            .frameTick(frame_tick),
            .reveal   (reveal[i]),
            .face     (face[i]),
            .flipping (flipping[i])
        );
    end

    // Stage 1: per-column/row window compares, no division
    logic          colHit, rowHit;
    logic [CW-1:0] colSel;
    logic [RW-1:0] rowSel;
    logic [HW-1:0] lxC, lyC, xBase, yBase;

    always_comb begin
        colHit = 1'b0; colSel = '0; lxC = '0; xBase = '0;
        rowHit = 1'b0; rowSel = '0; lyC = '0; yBase = '0;
        for (int c = 0; c < COLS; c++) begin
            xBase = HW'(X0 + c * (CARD_W + GAP));
            if (HCount >= xBase && HCount < xBase + HW'(CARD_W)) begin
                colHit = 1'b1;
                colSel = CW'(c);
                lxC    = HCount - xBase;
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            yBase = HW'(Y0 + r * (CARD_H + GAP));
            if (VCount >= yBase && VCount < yBase + HW'(CARD_H)) begin
                rowHit = 1'b1;
                rowSel = RW'(r);
                lyC    = VCount - yBase;
            end
        end
    end

    logic          s1Vid, s1Hit;
    logic [IW-1:0] s1Idx;
    logic [HW-1:0] s1Lx, s1Ly;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1Vid <= 1'b0;
            s1Hit <= 1'b0;
            s1Idx <= '0;
            s1Lx  <= '0;
            s1Ly  <= '0;
        end else begin
            s1Vid <= video_on;
            s1Hit <= colHit && rowHit;
            s1Idx <= (colHit && rowHit) ? IW'(int'(rowSel) * COLS + int'(colSel)) : '0;
            s1Lx  <= lxC;
            s1Ly  <= lyC;
        end
    end

    // Stage 2: symbol lookup and colour priority
    logic [SYM_W-1:0] symCur;
    logic             border, inner;
    logic [2:0]       rgbNext;

    always_comb begin
        symCur = symTab[s1Idx];
        border = s1Lx < HW'(2) || s1Lx >= HW'(CARD_W - 2) ||
                 s1Ly < HW'(2) || s1Ly >= HW'(CARD_H - 2);
        inner  = s1Lx >= HW'(CARD_W / 4) && s1Lx < HW'(3 * CARD_W / 4) &&
                 s1Ly >= HW'(CARD_H / 4) && s1Ly < HW'(3 * CARD_H / 4);
        if (!s1Vid || !s1Hit)                             rgbNext = CLR_BG;
        else if (cursor_en && s1Idx == cursor && border)  rgbNext = CLR_CURSOR;
        else if (flipping[s1Idx])                         rgbNext = CLR_FLIP;
        else if (!face[s1Idx])                            rgbNext = CLR_BACK;
        else if (matched[s1Idx])                          rgbNext = CLR_MATCH;
        else if (inner)                                   rgbNext = symCur[2:0];
        else                                              rgbNext = CLR_FACE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb      <= '0;
            card_hit <= 1'b0;
            card_idx <= '0;
            busy     <= 1'b0;
            symTab   <= '0;
        end else begin
            rgb      <= rgbNext;
            card_hit <= s1Hit;
            card_idx <= s1Idx;
            busy     <= |flipping;
            if (sym_we) symTab[sym_addr] <= sym_data;
        end
    end

endmodule

// File: tb/tb_card_grid_draw.sv
// Directed bench for card_grid_draw at default parameters; expected colours are hand-derived.
module tb_card_grid_draw;
    localparam int N  = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [9:0]    HCount, VCount;
    logic          video_on, frame_tick, sym_we, cursor_en;
    logic [IW-1:0] sym_addr, cursor;
    logic [3:0]    sym_data;
    logic [N-1:0]  reveal, matched;
    logic [2:0]    rgb;
    logic          card_hit, busy;
    logic [IW-1:0] card_idx;

    int nCmp = 0;
    int nBad = 0;

    card_grid_draw dut (
        .clk(clk), .reset_n(reset_n), .HCount(HCount), .VCount(VCount), .video_on(video_on),
        .frame_tick(frame_tick), .sym_we(sym_we), .sym_addr(sym_addr), .sym_data(sym_data),
        .reveal(reveal), .matched(matched), .cursor_en(cursor_en), .cursor(cursor),
        .rgb(rgb), .card_hit(card_hit), .card_idx(card_idx), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        if (obs !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // drive a pixel and wait out the 2-cycle pipeline; sample 1 time unit after the edge
    task automatic pix(input int h, input int v, input logic vid);
        HCount   = 10'(h);
        VCount   = 10'(v);
        video_on = vid;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
    endtask

    initial begin
        logic expBusy, expFace;
        reset_n = 1'b0; HCount = 10'd140; VCount = 10'd75; video_on = 1'b1;
        frame_tick = 1'b0; sym_we = 1'b0; sym_addr = '0; sym_data = '0;
        reveal = '0; matched = '0; cursor_en = 1'b0; cursor = '0;
        #2;
        chk("rst_rgb", 32'(rgb), 0);
        chk("rst_hit", 32'(card_hit), 0);
        chk("rst_busy", 32'(busy), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        pix(140, 75, 1'b1);
        chk("back_rgb", 32'(rgb), 3'b001);
        chk("back_hit", 32'(card_hit), 1);
        chk("back_idx", 32'(card_idx), 1);
        pix(125, 75, 1'b1);
        chk("gap_rgb", 32'(rgb), 0);
        chk("gap_hit", 32'(card_hit), 0);
        chk("gap_idx", 32'(card_idx), 0);
        pix(140, 75, 1'b0);
        chk("blank_rgb", 32'(rgb), 0);
        pix(260, 185, 1'b1);
        chk("idx6", 32'(card_idx), 6);

        // first flip of card 1 with symbol 5
        sym_addr = 4'd1; sym_data = 4'd5; sym_we = 1'b1;
        @(posedge clk); #1;
        sym_we = 1'b0;
        reveal[1] = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            tick();
            pix(140, 75, 1'b1);
            chk($sformatf("f1_busy_t%0d", k), 32'(busy), (k < 8) ? 1 : 0);
            chk($sformatf("f1_rgb_t%0d", k), 32'(rgb), (k < 8) ? 3'b110 : 3'b111);
        end
        pix(180, 75, 1'b1);
        chk("sym_inner", 32'(rgb), 3'b101);
        pix(145, 35, 1'b1);
        chk("face_outer", 32'(rgb), 3'b111);

        cursor_en = 1'b1; cursor = 4'd1;
        pix(140, 75, 1'b1);
        chk("cursor_edge", 32'(rgb), 3'b100);
        matched[1] = 1'b1;
        pix(145, 35, 1'b1);
        chk("matched", 32'(rgb), 3'b010);
        cursor = 4'd0;
        pix(140, 75, 1'b1);
        chk("cursor_other", 32'(rgb), 3'b010);
        cursor_en = 1'b0; matched = '0;

        // card 5: reveal drops mid-flip, taking effect only after the first flip completes
        reveal[5] = 1'b1;
        for (int k = 0; k <= 17; k++) begin
            if (k == 3) reveal[5] = 1'b0;
            tick();
            pix(145, 145, 1'b1);
            expBusy = (k < 8) || (k >= 9 && k < 17);
            expFace = (k >= 8 && k < 17);
            chk($sformatf("f2_busy_t%0d", k), 32'(busy), 32'(expBusy));
            chk($sformatf("f2_rgb_t%0d", k), 32'(rgb),
                expBusy ? 3'b110 : (expFace ? 3'b111 : 3'b001));
        end
        chk("f2_idx", 32'(card_idx), 5);

        // reset during a flip clears everything immediately
        reveal[5] = 1'b1;
        for (int k = 0; k <= 4; k++) tick();
        pix(145, 145, 1'b1);
        chk("pre_rst_busy", 32'(busy), 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_rgb", 32'(rgb), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_hit", 32'(card_hit), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        pix(140, 75, 1'b1);
        chk("post_rst_rgb", 32'(rgb), 3'b001);
        chk("post_rst_busy", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
